// File: rtl/hazard_pkg.sv
// Shared opcode constants and FSM state encoding for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JN  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LDM = 4'hD;
  localparam logic [3:0] OP_LDD = 4'hE;
  localparam logic [3:0] OP_LDI = 4'hF;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hazard_state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LDM) || (op == OP_LDD) || (op == OP_LDI);
  endfunction

  function automatic logic op_is_branch(input logic [3:0] op);
    return (op == OP_JZ) || (op == OP_JN) || (op == OP_JC) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones; used for the optional hazard statistics.
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush/redirect control for the IF/ID and ID/EX registers.
// Optional stall/flush statistics counters are built when HAZARD_STATS_EN is defined.
//
// state | meaning
// RUN   | normal issue; detects load-use hazards and taken branches (Mealy outputs)
// STALL | sustaining the remaining bubbles of a multi-cycle load-use stall
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic [1:0] id_ra,
  input  logic [1:0] id_rb,
  input  logic       id_uses_ra,
  input  logic       id_uses_rb,
  input  logic       ex_valid,
  input  logic [3:0] ex_opcode,
  input  logic [1:0] ex_ra,
  input  logic       ex_cond_met,
  input  logic [7:0] ex_target,
  output logic       idex_stall,
  output logic       idex_flush,
  output logic       ifid_hold,
  output logic       ifid_flush,
  output logic       pc_write,
  output logic       pc_sel,
`ifdef HAZARD_STATS_EN
  output logic [7:0] pc_target,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
`else
  output logic [7:0] pc_target
`endif
);

  hazard_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             take, luse;

  // Opcode is carried for debug/statistics builds only; hazard detection ignores it.
  logic unused_id_opcode;
  assign unused_id_opcode = ^id_opcode;

  assign take = ex_valid && op_is_branch(ex_opcode)
                && (ex_cond_met || (ex_opcode == OP_JMP));

  assign luse = ex_valid && op_is_load(ex_opcode) && id_valid
                && ((id_uses_ra && (id_ra == ex_ra)) || (id_uses_rb && (id_rb == ex_ra)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idex_stall = 1'b0;
    idex_flush = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    pc_write   = 1'b1;
    pc_sel     = 1'b0;
    pc_target  = 8'h00;

    if (!reset) begin
      unique case (state_q)
        RUN: begin
          // A taken branch squashes the ID instruction, so any load-use on it is moot.
          if (take) begin
            idex_flush = 1'b1;
            ifid_flush = 1'b1;
            pc_sel     = 1'b1;
            pc_target  = ex_target;
          end else if (luse) begin
            idex_stall = 1'b1;
            ifid_hold  = 1'b1;
            pc_write   = 1'b0;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = STALL;
              cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 2);
            end
          end
        end
        STALL: begin
          idex_stall = 1'b1;
          ifid_hold  = 1'b1;
          pc_write   = 1'b0;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  sat_counter16 u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (idex_stall),
    .count_o (stall_count)
  );

  sat_counter16 u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (idex_flush),
    .count_o (flush_count)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl; runs a 1-bubble and a 3-bubble instance side by side.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_ra, id_uses_rb, ex_valid, ex_cond_met;
  logic [3:0] id_opcode, ex_opcode;
  logic [1:0] id_ra, id_rb, ex_ra;
  logic [7:0] ex_target;

  logic       a_stall, a_flush, a_hold, a_iflush, a_pcw, a_pcs;
  logic [7:0] a_tgt;
  logic       b_stall, b_flush, b_hold, b_iflush, b_pcw, b_pcs;
  logic [7:0] b_tgt;
`ifdef HAZARD_STATS_EN
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_ra(ex_ra),
    .ex_cond_met(ex_cond_met), .ex_target(ex_target),
    .idex_stall(a_stall), .idex_flush(a_flush), .ifid_hold(a_hold),
    .ifid_flush(a_iflush), .pc_write(a_pcw), .pc_sel(a_pcs),
`ifdef HAZARD_STATS_EN
    .pc_target(a_tgt), .stall_count(a_sc), .flush_count(a_fc)
`else
    .pc_target(a_tgt)
`endif
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_ra(ex_ra),
    .ex_cond_met(ex_cond_met), .ex_target(ex_target),
    .idex_stall(b_stall), .idex_flush(b_flush), .ifid_hold(b_hold),
    .ifid_flush(b_iflush), .pc_write(b_pcw), .pc_sel(b_pcs),
`ifdef HAZARD_STATS_EN
    .pc_target(b_tgt), .stall_count(b_sc), .flush_count(b_fc)
`else
    .pc_target(b_tgt)
`endif
  );

  typedef struct {
    logic [13:0] e1;
    logic [13:0] e3;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rem1 = 0, rem3 = 0;
  int   sc1 = 0, sc3 = 0, fc1 = 0, fc3 = 0;

  localparam logic [13:0] IDLE_V  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
  localparam logic [13:0] STALL_V = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

  // rem = bubbles still owed after the current cycle
  task automatic model(input int n, input logic tk, input logic lu, input logic [7:0] tgt,
                       inout int rem, output logic [13:0] e);
    if (rem > 0) begin
      e = STALL_V;
      rem--;
    end else if (tk) begin
      e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, tgt};
    end else if (lu) begin
      e = STALL_V;
      rem = n - 1;
    end else begin
      e = IDLE_V;
    end
  endtask

  task automatic step(input string tag, input logic rst,
                      input logic xv, input logic [3:0] xop, input logic [1:0] xra,
                      input logic cond, input logic [7:0] tgt,
                      input logic iv, input logic [1:0] ira, input logic [1:0] irb,
                      input logic ua, input logic ub);
    logic tk, lu;
    logic [13:0] obs1, obs3;
    exp_t e, got;
    @(posedge clk);
    #1;
    reset = rst; ex_valid = xv; ex_opcode = xop; ex_ra = xra; ex_cond_met = cond;
    ex_target = tgt; id_valid = iv; id_ra = ira; id_rb = irb;
    id_uses_ra = ua; id_uses_rb = ub; id_opcode = 4'h3;
    tk = xv && (xop inside {OP_JZ, OP_JN, OP_JC, OP_JMP}) && (cond || xop == OP_JMP);
    lu = xv && (xop inside {OP_LDM, OP_LDD, OP_LDI}) && iv
         && ((ua && ira == xra) || (ub && irb == xra));
    if (rst) begin
      rem1 = 0; rem3 = 0; sc1 = 0; sc3 = 0; fc1 = 0; fc3 = 0;
    end else begin
      model(1, tk, lu, tgt, rem1, e.e1);
      model(3, tk, lu, tgt, rem3, e.e3);
      sc1 += int'(e.e1[13]); fc1 += int'(e.e1[12]);
      sc3 += int'(e.e3[13]); fc3 += int'(e.e3[12]);
      e.tag = tag;
      q.push_back(e);
    end
    @(negedge clk);
    if (!rst) begin
      got  = q.pop_front();
      obs1 = {a_stall, a_flush, a_hold, a_iflush, a_pcw, a_pcs, a_tgt};
      obs3 = {b_stall, b_flush, b_hold, b_iflush, b_pcw, b_pcs, b_tgt};
      n_vec++;
      assert (obs1 === got.e1) else begin
        n_err++;
        $error("FAIL %s n1 observed %h expected %h", got.tag, obs1, got.e1);
      end
      n_vec++;
      assert (obs3 === got.e3) else begin
        n_err++;
        $error("FAIL %s n3 observed %h expected %h", got.tag, obs3, got.e3);
      end
    end
  endtask

  task automatic bub(input string tag);
    step(tag, 1'b0, 1'b0, OP_NOP, 2'd0, 1'b0, 8'h00, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_opcode = 4'h0; id_ra = 2'd0; id_rb = 2'd0;
    id_uses_ra = 1'b0; id_uses_rb = 1'b0; ex_valid = 1'b0; ex_opcode = OP_NOP;
    ex_ra = 2'd0; ex_cond_met = 1'b0; ex_target = 8'h00;

    step("rst", 1'b1, 0, OP_NOP, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    step("rst", 1'b1, 0, OP_NOP, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    step("reset_idle", 1'b0, 0, OP_NOP, 0, 0, 8'h00, 0, 0, 0, 0, 0);

    step("luse_ra", 1'b0, 1, OP_LDM, 2'd2, 0, 8'h00, 1, 2'd2, 2'd0, 1, 0);
    bub("luse_b1");
    bub("luse_b2");
    bub("luse_done");

    step("br_taken", 1'b0, 1, OP_JZ, 2'd0, 1, 8'h40, 1, 2'd1, 2'd1, 1, 1);
    step("br_not_taken", 1'b0, 1, OP_JZ, 2'd0, 0, 8'h55, 1, 2'd1, 2'd1, 1, 1);
    step("jmp_uncond", 1'b0, 1, OP_JMP, 2'd0, 0, 8'h10, 1, 2'd0, 2'd0, 0, 0);
    step("jn_taken", 1'b0, 1, OP_JN, 2'd3, 1, 8'hA5, 0, 2'd0, 2'd0, 0, 0);
    step("jc_invalid", 1'b0, 0, OP_JC, 2'd0, 1, 8'h77, 1, 2'd0, 2'd0, 0, 0);

    step("load_nodep", 1'b0, 1, OP_LDD, 2'd1, 0, 8'h00, 1, 2'd2, 2'd3, 1, 1);
    step("load_unused_ra", 1'b0, 1, OP_LDI, 2'd3, 0, 8'h00, 1, 2'd3, 2'd0, 0, 1);
    step("load_id_invalid", 1'b0, 1, OP_LDM, 2'd2, 0, 8'h00, 0, 2'd2, 2'd2, 1, 1);
    step("load_ex_invalid", 1'b0, 0, OP_LDM, 2'd2, 0, 8'h00, 1, 2'd2, 2'd2, 1, 1);
    step("nonload_dep", 1'b0, 1, 4'h5, 2'd2, 0, 8'h00, 1, 2'd2, 2'd2, 1, 1);

    step("luse_rb", 1'b0, 1, OP_LDI, 2'd1, 0, 8'h00, 1, 2'd3, 2'd1, 0, 1);
    bub("rb_b1");
    bub("rb_b2");
    step("b2b_load", 1'b0, 1, OP_LDD, 2'd0, 0, 8'h00, 1, 2'd0, 2'd2, 1, 1);
    bub("b2b_b1");
    bub("b2b_b2");
    bub("b2b_done");

    step("luse_pre_rst", 1'b0, 1, OP_LDM, 2'd2, 0, 8'h00, 1, 2'd2, 2'd0, 1, 0);
    step("rst_in_stall", 1'b1, 0, OP_NOP, 0, 0, 8'h00, 1, 2'd2, 2'd0, 1, 0);
    bub("after_rst");

    step("stats_luse1", 1'b0, 1, OP_LDM, 2'd2, 0, 8'h00, 1, 2'd2, 2'd0, 1, 0);
    bub("stats_b1");
    bub("stats_b2");
    step("stats_luse2", 1'b0, 1, OP_LDD, 2'd1, 0, 8'h00, 1, 2'd0, 2'd1, 0, 1);
    bub("stats_b3");
    bub("stats_b4");
    step("stats_br", 1'b0, 1, OP_JC, 2'd0, 1, 8'h2C, 1, 2'd0, 2'd0, 0, 0);
    bub("stats_end");

`ifdef HAZARD_STATS_EN
    n_vec++;
    assert (a_sc === 16'(sc1)) else begin
      n_err++; $error("FAIL stall_count n1 observed %0d expected %0d", a_sc, sc1);
    end
    n_vec++;
    assert (a_fc === 16'(fc1)) else begin
      n_err++; $error("FAIL flush_count n1 observed %0d expected %0d", a_fc, fc1);
    end
    n_vec++;
    assert (b_sc === 16'(sc3)) else begin
      n_err++; $error("FAIL stall_count n3 observed %0d expected %0d", b_sc, sc3);
    end
    n_vec++;
    assert (b_fc === 16'(fc3)) else begin
      n_err++; $error("FAIL flush_count n3 observed %0d expected %0d", b_fc, fc3);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the stall/flush/redirect side of the ID/EX register and the IF/ID register, plus the PC write-enable and PC mux select.
- Detects load-use hazards between the ID-stage instruction and the instruction in EX, then holds the front end for a programmable number of cycles.
- Resolves taken branches reported by EX: redirects the PC and squashes the younger instructions.
- Mealy outputs are asserted in the detection cycle; an FSM and a down-counter sustain multi-cycle actions.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubbles inserted per load-use hazard (legal 1..7).
- CNT_W, 3, width of the stall down-counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID-stage instruction is valid
- id_opcode  in  4  ID-stage opcode (unused for hazard detection; kept for the stats option)
- id_ra  in  2  ID source register A
- id_rb  in  2  ID source register B
- id_uses_ra  in  1  ID instruction reads ra
- id_uses_rb  in  1  ID instruction reads rb
- ex_valid  in  1  ID/EX valid output
- ex_opcode  in  4  ID/EX opcode output
- ex_ra  in  2  ID/EX destination register
- ex_cond_met  in  1  EX branch condition evaluated true (combinational from the ALU flags)
- ex_target  in  8  EX branch target address
- idex_stall  out  1  insert a bubble into ID/EX
- idex_flush  out  1  clear ID/EX
- ifid_hold  out  1  IF/ID keeps its contents
- ifid_flush  out  1  clear IF/ID
- pc_write  out  1  PC update enable
- pc_sel  out  1  0 = sequential PC, 1 = pc_target
- pc_target  out  8  redirect address

Behaviour:
- Reset values: all outputs are 0 except pc_write=1; FSM=RUN; cnt=0.
- is_load = ex_opcode in {OP_LDM, OP_LDD, OP_LDI}.
- is_branch = ex_opcode in {OP_JZ, OP_JN, OP_JC, OP_JMP}. OP_JMP is treated as taken regardless of ex_cond_met.
- take = ex_valid & is_branch & (ex_cond_met | ex_opcode==OP_JMP).
- luse = ex_valid & is_load & id_valid & ((id_uses_ra & id_ra==ex_ra) | (id_uses_rb & id_rb==ex_ra)).
- FSM states: RUN, STALL.
- RUN, take (highest priority):
  - idex_flush=1, ifid_flush=1, pc_sel=1, pc_target=ex_target, pc_write=1 in the same cycle.
  - Next state is RUN.
  - A simultaneous luse is discarded, because the ID instruction is squashed.
- RUN, luse and not take:
  - idex_stall=1, ifid_hold=1, pc_write=0.
  - If LOAD_STALL_CYCLES>1: next state is STALL, cnt=LOAD_STALL_CYCLES-2.
  - Otherwise stay in RUN.
- RUN, neither: all control outputs are 0 and pc_write=1.
- STALL:
  - idex_stall=1, ifid_hold=1, pc_write=0.
  - If cnt==0, go to RUN; else cnt decrements.
  - take is not evaluated in STALL; EX holds a bubble, so ex_valid=0 is guaranteed.
- Outside a redirect cycle, pc_target is 0 and pc_sel is 0.
- A load followed by a non-dependent instruction produces no stall.
- Back-to-back loads each trigger independently once they reach EX.
- Reset asserted in STALL returns to RUN on the next edge; no residual stall cycle.
- No combinational path exists from outputs back to inputs inside the block.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, the block adds two ports, stall_count (out, 16) and flush_count (out, 16).
  - stall_count increments once per cycle with idex_stall=1.
  - flush_count increments once per cycle with idex_flush=1.
  - Both saturate at 16'hFFFF and are cleared by reset.
- When not defined, the ports and the counters are absent and the behaviour is otherwise identical.

Decomposition:
- hazard_pkg holds:
  - opcode constants: OP_NOP=4'h0, OP_JZ=4'h9, OP_JN=4'hA, OP_JC=4'hB, OP_JMP=4'hC, OP_LDM=4'hD, OP_LDD=4'hE, OP_LDI=4'hF;
  - the FSM state encoding (RUN=1'b0, STALL=1'b1).
- The block is a single module; the optional sat_counter16 sub-module is instantiated twice under HAZARD_STATS_EN.

Test Plan:
- Load-use: ex=OP_LDM, ex_ra=2, ex_valid=1; id_ra=2, id_uses_ra=1, id_valid=1 -> idex_stall=1, ifid_hold=1, pc_write=0 for exactly 1 cycle (LOAD_STALL_CYCLES=1).
- LOAD_STALL_CYCLES=3 with the same stimulus -> 3 consecutive stall cycles, then pc_write=1 and the FSM is in RUN.
- Taken branch: ex=OP_JZ, ex_cond_met=1, ex_target=8'h40 -> same cycle idex_flush=1, ifid_flush=1, pc_sel=1, pc_target=8'h40.
- Not-taken branch: OP_JZ with ex_cond_met=0 -> no flush, pc_sel=0.
- OP_JMP with ex_cond_met=0, target 8'h10 -> flush and redirect to 8'h10.
- Reset pulsed in the 2nd cycle of a 3-cycle stall -> next cycle all controls are 0, pc_write=1.
- Under HAZARD_STATS_EN: 2 load-use stalls plus 1 taken branch -> stall_count=2, flush_count=1.
